// File: rtl/reservation_station.sv
// ----------------------------------------------------------------------------
// reservation_station
//   Buffers dispatched ALU/branch instructions until both source operands are
//   available, snoops the ALU and LSB result broadcasts to wake waiting
//   operands, and issues at most one ready instruction per cycle onto a
//   registered bus that feeds the combinational ALU.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low freezes all state and outputs
//   in_rollback         misprediction flush (empties the station)
//   in_disp_*           dispatch request: opcode, source tags/values,
//                       immediate, PC, destination ROB tag
//   in_alu_tag/value    ALU result broadcast (tag 0 = none)
//   in_lsb_tag/value    LSB result broadcast (tag 0 = none)
//   out_full            every entry is busy (combinational)
//   out_op ... out_rob_tag
//                       issue bus; NOP / zero when nothing issues
// ----------------------------------------------------------------------------
module reservation_station #(
    parameter int RS_SIZE = 16,
    parameter int TAG_W   = 4,
    parameter int OP_W    = 6,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              in_rollback,

    input  logic              in_disp_valid,
    input  logic [OP_W-1:0]   in_disp_op,
    input  logic [TAG_W-1:0]  in_disp_q1,
    input  logic [TAG_W-1:0]  in_disp_q2,
    input  logic [DATA_W-1:0] in_disp_v1,
    input  logic [DATA_W-1:0] in_disp_v2,
    input  logic [DATA_W-1:0] in_disp_imm,
    input  logic [DATA_W-1:0] in_disp_pc,
    input  logic [TAG_W-1:0]  in_disp_tag,

    input  logic [TAG_W-1:0]  in_alu_tag,
    input  logic [DATA_W-1:0] in_alu_value,
    input  logic [TAG_W-1:0]  in_lsb_tag,
    input  logic [DATA_W-1:0] in_lsb_value,

    output logic              out_full,
    output logic [OP_W-1:0]   out_op,
    output logic [DATA_W-1:0] out_value1,
    output logic [DATA_W-1:0] out_value2,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_pc,
    output logic [TAG_W-1:0]  out_rob_tag
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
    localparam logic [OP_W-1:0] OPENUM_NOP = '0;

    // ------------------------------------------------------------------
    // Entry storage. Only the busy bits need a reset; payload fields are
    // don't-care while their entry is free.
    // ------------------------------------------------------------------
    logic [RS_SIZE-1:0] busy;
    logic [OP_W-1:0]    e_op  [RS_SIZE];
    logic [TAG_W-1:0]   e_q1  [RS_SIZE];
    logic [TAG_W-1:0]   e_q2  [RS_SIZE];
    logic [DATA_W-1:0]  e_v1  [RS_SIZE];
    logic [DATA_W-1:0]  e_v2  [RS_SIZE];
    logic [DATA_W-1:0]  e_imm [RS_SIZE];
    logic [DATA_W-1:0]  e_pc  [RS_SIZE];
    logic [TAG_W-1:0]   e_tag [RS_SIZE];

    // ------------------------------------------------------------------
    // Ready vector and lowest-index selection for issue and for allocation.
    // Both are judged on pre-edge state, so a slot freed by this cycle's
    // issue is not handed to this cycle's dispatch.
    // ------------------------------------------------------------------
    logic [RS_SIZE-1:0] ready;
    logic               issue_found;
    logic [IDX_W-1:0]   issue_idx;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;

    always_comb begin
        ready = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            ready[i] = busy[i] && (e_q1[i] == '0) && (e_q2[i] == '0);
        end
    end

    always_comb begin
        issue_found = 1'b0;
        issue_idx   = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (ready[i] && !issue_found) begin
                issue_found = 1'b1;
                issue_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (!busy[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign out_full = &busy;

    logic disp_accept;
    assign disp_accept = in_disp_valid && !out_full;

    // ------------------------------------------------------------------
    // Same-cycle forwarding for the dispatched operands. The LSB check
    // comes last so it wins if both broadcasts carry the same tag.
    // ------------------------------------------------------------------
    logic [TAG_W-1:0]  disp_q1;
    logic [TAG_W-1:0]  disp_q2;
    logic [DATA_W-1:0] disp_v1;
    logic [DATA_W-1:0] disp_v2;

    always_comb begin
        disp_q1 = in_disp_q1;
        disp_v1 = in_disp_v1;
        disp_q2 = in_disp_q2;
        disp_v2 = in_disp_v2;
        if (in_disp_q1 != '0 && in_disp_q1 == in_alu_tag) begin
            disp_q1 = '0;
            disp_v1 = in_alu_value;
        end
        if (in_disp_q1 != '0 && in_disp_q1 == in_lsb_tag) begin
            disp_q1 = '0;
            disp_v1 = in_lsb_value;
        end
        if (in_disp_q2 != '0 && in_disp_q2 == in_alu_tag) begin
            disp_q2 = '0;
            disp_v2 = in_alu_value;
        end
        if (in_disp_q2 != '0 && in_disp_q2 == in_lsb_tag) begin
            disp_q2 = '0;
            disp_v2 = in_lsb_value;
        end
    end

    // ------------------------------------------------------------------
    // State update: issue, wake-up and allocation. Issue touches a busy
    // slot and allocation a free one, so their writes never collide; the
    // wake-up loop only touches busy slots.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= '0;
            out_op      <= OPENUM_NOP;
            out_value1  <= '0;
            out_value2  <= '0;
            out_imm     <= '0;
            out_pc      <= '0;
            out_rob_tag <= '0;
        end else if (rdy) begin
            if (in_rollback) begin
                busy        <= '0;
                out_op      <= OPENUM_NOP;
                out_value1  <= '0;
                out_value2  <= '0;
                out_imm     <= '0;
                out_pc      <= '0;
                out_rob_tag <= '0;
            end else begin
                if (issue_found) begin
                    out_op            <= e_op[issue_idx];
                    out_value1        <= e_v1[issue_idx];
                    out_value2        <= e_v2[issue_idx];
                    out_imm           <= e_imm[issue_idx];
                    out_pc            <= e_pc[issue_idx];
                    out_rob_tag       <= e_tag[issue_idx];
                    busy[issue_idx]   <= 1'b0;
                end else begin
                    out_op      <= OPENUM_NOP;
                    out_value1  <= '0;
                    out_value2  <= '0;
                    out_imm     <= '0;
                    out_pc      <= '0;
                    out_rob_tag <= '0;
                end

                // Later assignments win, giving the LSB priority on a tag tie.
                for (int unsigned i = 0; i < RS_SIZE; i++) begin
                    if (busy[i]) begin
                        if (e_q1[i] != '0 && e_q1[i] == in_alu_tag) begin
                            e_v1[i] <= in_alu_value;
                            e_q1[i] <= '0;
                        end
                        if (e_q1[i] != '0 && e_q1[i] == in_lsb_tag) begin
                            e_v1[i] <= in_lsb_value;
                            e_q1[i] <= '0;
                        end
                        if (e_q2[i] != '0 && e_q2[i] == in_alu_tag) begin
                            e_v2[i] <= in_alu_value;
                            e_q2[i] <= '0;
                        end
                        if (e_q2[i] != '0 && e_q2[i] == in_lsb_tag) begin
                            e_v2[i] <= in_lsb_value;
                            e_q2[i] <= '0;
                        end
                    end
                end

                if (disp_accept) begin
                    busy[free_idx]  <= 1'b1;
                    e_op[free_idx]  <= in_disp_op;
                    e_q1[free_idx]  <= disp_q1;
                    e_q2[free_idx]  <= disp_q2;
                    e_v1[free_idx]  <= disp_v1;
                    e_v2[free_idx]  <= disp_v2;
                    e_imm[free_idx] <= in_disp_imm;
                    e_pc[free_idx]  <= in_disp_pc;
                    e_tag[free_idx] <= in_disp_tag;
                end
            end
        end
    end

    // A dispatch that arrives while full is dropped by the logic above;
    // flag it in simulation because the dispatcher should have stalled.
    always_ff @(posedge clk) begin
        if (!rst && rdy && !in_rollback) begin
            assert (!(in_disp_valid && out_full))
                else $warning("reservation_station: dispatch dropped while station full");
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
module tb_reservation_station;

    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_ADDI = 6'd3;
    localparam logic [5:0] OP_BEQ  = 6'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        in_rollback = 1'b0;
    logic        in_disp_valid = 1'b0;
    logic [5:0]  in_disp_op = '0;
    logic [3:0]  in_disp_q1 = '0;
    logic [3:0]  in_disp_q2 = '0;
    logic [31:0] in_disp_v1 = '0;
    logic [31:0] in_disp_v2 = '0;
    logic [31:0] in_disp_imm = '0;
    logic [31:0] in_disp_pc = '0;
    logic [3:0]  in_disp_tag = '0;
    logic [3:0]  in_alu_tag = '0;
    logic [31:0] in_alu_value = '0;
    logic [3:0]  in_lsb_tag = '0;
    logic [31:0] in_lsb_value = '0;
    logic        out_full;
    logic [5:0]  out_op;
    logic [31:0] out_value1;
    logic [31:0] out_value2;
    logic [31:0] out_imm;
    logic [31:0] out_pc;
    logic [3:0]  out_rob_tag;

    reservation_station #(
        .RS_SIZE(16),
        .TAG_W(4),
        .OP_W(6),
        .DATA_W(32)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .in_rollback(in_rollback),
        .in_disp_valid(in_disp_valid), .in_disp_op(in_disp_op),
        .in_disp_q1(in_disp_q1), .in_disp_q2(in_disp_q2),
        .in_disp_v1(in_disp_v1), .in_disp_v2(in_disp_v2),
        .in_disp_imm(in_disp_imm), .in_disp_pc(in_disp_pc),
        .in_disp_tag(in_disp_tag),
        .in_alu_tag(in_alu_tag), .in_alu_value(in_alu_value),
        .in_lsb_tag(in_lsb_tag), .in_lsb_value(in_lsb_value),
        .out_full(out_full), .out_op(out_op),
        .out_value1(out_value1), .out_value2(out_value2),
        .out_imm(out_imm), .out_pc(out_pc), .out_rob_tag(out_rob_tag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  tag;
    } issue_t;

    typedef struct {
        logic [5:0]  op;
        logic [3:0]  q1;
        logic [3:0]  q2;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  tag;
        logic [3:0]  alu_tag;
        logic [31:0] alu_val;
        logic [3:0]  lsb_tag;
        logic [31:0] lsb_val;
        logic [31:0] exp_v1;
        logic [31:0] exp_v2;
    } vec_t;

    issue_t sb_q[$];
    vec_t   vecs[6];
    int     n_pass = 0;
    int     n_total = 0;

    function automatic issue_t mk_issue(logic [5:0] op, logic [31:0] v1, logic [31:0] v2,
                                        logic [31:0] imm, logic [31:0] pc, logic [3:0] tag);
        issue_t r;
        r.op = op; r.v1 = v1; r.v2 = v2; r.imm = imm; r.pc = pc; r.tag = tag;
        return r;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Compares the issue bus after every enabled edge: a non-NOP issue is
    // matched against the scoreboard head, a NOP cycle must carry zeros.
    task automatic monitor();
        issue_t act;
        issue_t exp;
        act = mk_issue(out_op, out_value1, out_value2, out_imm, out_pc, out_rob_tag);
        n_total++;
        if (out_op != OP_NOP) begin
            if (sb_q.size() == 0) begin
                $display("FAIL unexpected_issue: got op=%0d tag=%0d pc=0x%0h, expected nothing",
                         out_op, out_rob_tag, out_pc);
            end else begin
                exp = sb_q.pop_front();
                if (act === exp) n_pass++;
                else $display("FAIL issue: got op=%0d v1=0x%0h v2=0x%0h imm=0x%0h pc=0x%0h tag=%0d expected op=%0d v1=0x%0h v2=0x%0h imm=0x%0h pc=0x%0h tag=%0d",
                              act.op, act.v1, act.v2, act.imm, act.pc, act.tag,
                              exp.op, exp.v1, exp.v2, exp.imm, exp.pc, exp.tag);
            end
        end else begin
            if (act === '0) n_pass++;
            else $display("FAIL nop_bus: got tag=%0d v1=0x%0h v2=0x%0h imm=0x%0h pc=0x%0h expected all zero",
                          out_rob_tag, out_value1, out_value2, out_imm, out_pc);
        end
    endtask

    task automatic tick();
        logic edge_live;
        @(posedge clk);
        edge_live = rdy && !rst;
        #1;
        if (edge_live) monitor();
    endtask

    task automatic disp(logic [5:0] op, logic [3:0] q1, logic [3:0] q2, logic [31:0] v1,
                        logic [31:0] v2, logic [31:0] imm, logic [31:0] pc, logic [3:0] tag);
        in_disp_valid = 1'b1;
        in_disp_op = op; in_disp_q1 = q1; in_disp_q2 = q2;
        in_disp_v1 = v1; in_disp_v2 = v2; in_disp_imm = imm;
        in_disp_pc = pc; in_disp_tag = tag;
    endtask

    task automatic idle();
        in_disp_valid = 1'b0;
        in_alu_tag = '0;
        in_lsb_tag = '0;
        in_rollback = 1'b0;
    endtask

    initial begin
        //                op       q1 q2 v1            v2            imm    pc     tag alu alu_val  lsb lsb_val exp_v1        exp_v2
        vecs[0] = '{OP_ADD,  4'd0, 4'd0, 32'd5,        32'd7,        32'h0, 32'h10, 4'd3, 4'd0, 32'h0,  4'd0, 32'h0, 32'd5,        32'd7};
        vecs[1] = '{OP_ADDI, 4'd4, 4'd0, 32'hDEAD,     32'h0,        32'h20, 32'h14, 4'd6, 4'd0, 32'h0, 4'd4, 32'd9, 32'd9,        32'h0};
        vecs[2] = '{OP_SUB,  4'd0, 4'd6, 32'd100,      32'hBEEF,     32'h0, 32'h18, 4'd7, 4'd6, 32'h55, 4'd0, 32'h0, 32'd100,      32'h55};
        vecs[3] = '{OP_BEQ,  4'd2, 4'd3, 32'h1,        32'h2,        32'h40, 32'h1C, 4'd8, 4'd2, 32'hA, 4'd3, 32'hB, 32'hA,        32'hB};
        vecs[4] = '{OP_ADD,  4'd5, 4'd5, 32'h3,        32'h4,        32'h0, 32'h20, 4'd9, 4'd5, 32'd1,  4'd5, 32'd2, 32'd2,        32'd2};
        vecs[5] = '{OP_ADD,  4'd0, 4'd0, 32'hFFFFFFFF, 32'h80000000, 32'h0, 32'h24, 4'd15, 4'd7, 32'h99, 4'd0, 32'h0, 32'hFFFFFFFF, 32'h80000000};

        // Reset
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("reset_full", 64'(out_full), 64'd0);
        check("reset_op", 64'(out_op), 64'(OP_NOP));
        check("reset_tag", 64'(out_rob_tag), 64'd0);

        // Table: back-to-back ready dispatches incl. same-cycle forwarding
        for (int i = 0; i < 6; i++) begin
            disp(vecs[i].op, vecs[i].q1, vecs[i].q2, vecs[i].v1, vecs[i].v2,
                 vecs[i].imm, vecs[i].pc, vecs[i].tag);
            in_alu_tag = vecs[i].alu_tag; in_alu_value = vecs[i].alu_val;
            in_lsb_tag = vecs[i].lsb_tag; in_lsb_value = vecs[i].lsb_val;
            sb_q.push_back(mk_issue(vecs[i].op, vecs[i].exp_v1, vecs[i].exp_v2,
                                    vecs[i].imm, vecs[i].pc, vecs[i].tag));
            tick();
            if (i == 0) check("first_issue_latency", 64'(out_op), 64'(OP_NOP));
        end
        idle();
        tick();
        tick();
        check("table_drained", 64'(sb_q.size()), 64'd0);

        // Wake-up timing: no issue before the broadcast edge plus one
        disp(OP_SUB, 4'd2, 4'd0, 32'h0, 32'd1, 32'h0, 32'h30, 4'd5);
        sb_q.push_back(mk_issue(OP_SUB, 32'h10, 32'd1, 32'h0, 32'h30, 4'd5));
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait_no_issue", 64'(out_op), 64'(OP_NOP));
        end
        in_alu_tag = 4'd2; in_alu_value = 32'h10;
        tick();
        idle();
        check("wake_edge_no_issue", 64'(out_op), 64'(OP_NOP));
        tick();
        check("wake_issue_op", 64'(out_op), 64'(OP_SUB));
        tick();
        check("wake_then_nop", 64'(out_op), 64'(OP_NOP));

        // Fill all 16 entries, drop the 17th, drain in index order
        for (int i = 0; i < 16; i++) begin
            disp(OP_ADD, 4'd7, 4'd0, 32'hBAD, 32'(i), 32'(i * 2), 32'(32'h400 + i * 4), 4'((i % 15) + 1));
            sb_q.push_back(mk_issue(OP_ADD, 32'd1, 32'(i), 32'(i * 2), 32'(32'h400 + i * 4), 4'((i % 15) + 1)));
            tick();
            if (i == 14) check("full_at_15", 64'(out_full), 64'd0);
        end
        check("full_at_16", 64'(out_full), 64'd1);
        disp(OP_SUB, 4'd0, 4'd0, 32'd1, 32'd1, 32'h0, 32'h999, 4'd15);
        tick();
        idle();
        check("full_after_drop", 64'(out_full), 64'd1);
        in_alu_tag = 4'd7; in_alu_value = 32'd1;
        tick();
        idle();
        for (int i = 0; i < 16; i++) begin
            tick();
            check("drain_consecutive", 64'(out_op), 64'(OP_ADD));
        end
        tick();
        check("drain_done_nop", 64'(out_op), 64'(OP_NOP));
        check("drain_done_full", 64'(out_full), 64'd0);

        // Two woken entries plus a dispatch into a freed slot during drain
        disp(OP_SUB, 4'd9, 4'd0, 32'h0, 32'd2, 32'h0, 32'h100, 4'd1);
        tick();
        disp(OP_ADD, 4'd9, 4'd0, 32'h0, 32'd3, 32'h0, 32'h104, 4'd2);
        tick();
        idle();
        sb_q.push_back(mk_issue(OP_SUB, 32'h40, 32'd2, 32'h0, 32'h100, 4'd1));
        sb_q.push_back(mk_issue(OP_ADD, 32'h40, 32'd3, 32'h0, 32'h104, 4'd2));
        sb_q.push_back(mk_issue(OP_ADD, 32'd8, 32'd9, 32'h0, 32'h10C, 4'd4));
        sb_q.push_back(mk_issue(OP_ADD, 32'd6, 32'd7, 32'h0, 32'h108, 4'd3));
        in_alu_tag = 4'd9; in_alu_value = 32'h40;
        tick();
        idle();
        disp(OP_ADD, 4'd0, 4'd0, 32'd6, 32'd7, 32'h0, 32'h108, 4'd3);
        tick();
        check("order_first", 64'(out_rob_tag), 64'd1);
        disp(OP_ADD, 4'd0, 4'd0, 32'd8, 32'd9, 32'h0, 32'h10C, 4'd4);
        tick();
        idle();
        check("order_second", 64'(out_rob_tag), 64'd2);
        tick();
        check("order_freed_slot", 64'(out_rob_tag), 64'd4);
        tick();
        check("order_last", 64'(out_rob_tag), 64'd3);
        tick();

        // Rollback with a full station and one entry about to issue
        for (int i = 0; i < 15; i++) begin
            disp(OP_ADD, 4'd8, 4'd0, 32'h0, 32'h0, 32'h0, 32'(32'h800 + i), 4'd1);
            tick();
        end
        disp(OP_SUB, 4'd0, 4'd0, 32'd1, 32'd2, 32'h0, 32'h900, 4'd9);
        tick();
        idle();
        check("rb_full_before", 64'(out_full), 64'd1);
        in_rollback = 1'b1;
        tick();
        idle();
        check("rb_full_after", 64'(out_full), 64'd0);
        check("rb_op_nop", 64'(out_op), 64'(OP_NOP));
        in_alu_tag = 4'd8; in_alu_value = 32'd5;
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rb_no_issue", 64'(out_op), 64'(OP_NOP));
        end

        // rdy low freezes the issue bus and entries; ignored inputs meanwhile
        disp(OP_SUB, 4'd0, 4'd0, 32'd3, 32'd4, 32'h0, 32'h200, 4'd10);
        sb_q.push_back(mk_issue(OP_SUB, 32'd3, 32'd4, 32'h0, 32'h200, 4'd10));
        tick();
        disp(OP_ADD, 4'd0, 4'd0, 32'd8, 32'd9, 32'h0, 32'h204, 4'd11);
        sb_q.push_back(mk_issue(OP_ADD, 32'd8, 32'd9, 32'h0, 32'h204, 4'd11));
        tick();
        rdy = 1'b0;
        disp(OP_BEQ, 4'd0, 4'd0, 32'd1, 32'd1, 32'h0, 32'h208, 4'd12);
        in_rollback = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_tag", 64'(out_rob_tag), 64'd10);
            check("hold_v1", 64'(out_value1), 64'd3);
        end
        rdy = 1'b1;
        idle();
        tick();
        check("resume_tag", 64'(out_rob_tag), 64'd11);
        tick();
        check("resume_then_nop", 64'(out_op), 64'(OP_NOP));
        tick();
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
